// File: rtl/rdxbar_arb_pkg.sv
// Shared types and helpers for the read-crossbar packet arbiter.
package rdxbar_arb_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  // Payload width: data plus the last-beat flag in the MSB.
  localparam int unsigned PLD_W      = DATA_WIDTH + 1;
  localparam int unsigned PKTCNT_W   = 16;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  // The MSB of a payload marks the final beat of a packet.
  function automatic logic is_last(input logic [PLD_W-1:0] pld);
    return pld[PLD_W-1];
  endfunction

endpackage

// File: rtl/rdxbar_rr_pick.sv
// Rotate-priority encoder: first asserted request scanning ptr, ptr+1, ... modulo N.
module rdxbar_rr_pick #(
  parameter int unsigned N = 4,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          any,
  output logic [IW-1:0] idx
);

  // Walk the N positions starting at ptr; the first hit wins.
  always_comb begin
    int unsigned pos;
    logic [IW-1:0] cand;
    any  = 1'b0;
    idx  = '0;
    pos  = 0;
    cand = '0;
    for (int unsigned i = 0; i < N; i++) begin
      pos  = (32'(ptr) + i) % N;
      cand = pos[IW-1:0];
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/rdxbar_pkt_arbiter.sv
// Packet-atomic round-robin arbiter sharing one read-crossbar output between N requesters.
// A winner owns the output until its last beat (payload MSB) is accepted, then one idle
// cycle follows before the next arbitration.
// Optional feature macro: RDXBAR_ARB_PKTCNT_EN adds saturating per-requester packet counters
// on oPktCnt.
module rdxbar_pkt_arbiter
  import rdxbar_arb_pkg::*;
#(
  parameter int unsigned DW = DATA_WIDTH + 1,
  parameter int unsigned AW = 4,
  parameter int unsigned N  = 4
) (
  input  logic                 iClk,
  input  logic                 iRst,
  input  logic [N-1:0]         iDcpIn_Vld,
  output logic [N-1:0]         iDcpIn_Rdy,
  input  logic [N*DW-1:0]      iDcpIn_Pld,
  input  logic [N*AW-1:0]      iDcpIn_Dst,
  output logic                 oDcpOut_Vld,
  input  logic                 oDcpOut_Rdy,
  output logic [DW-1:0]        oDcpOut_Pld,
  output logic [AW-1:0]        oDcpOut_Dst,
  output logic                 oBusy,
  output logic [$clog2(N)-1:0] oGrantIdx
`ifdef RDXBAR_ARB_PKTCNT_EN
  ,
  output logic [N*PKTCNT_W-1:0] oPktCnt
`endif
);

  localparam int unsigned   IW      = $clog2(N);
  localparam logic [IW-1:0] LastIdx = IW'(N - 1);

  arb_state_e    state_q;
  logic [IW-1:0] grant_q;
  logic [IW-1:0] ptr_q;

  logic          pick_any;
  logic [IW-1:0] pick_idx;
  logic          beat_fire;
  logic          beat_last;

  logic [DW-1:0] pld_arr [N];
  logic [AW-1:0] dst_arr [N];

  for (genvar k = 0; k < N; k++) begin : g_unpack
    assign pld_arr[k] = iDcpIn_Pld[k*DW +: DW];
    assign dst_arr[k] = iDcpIn_Dst[k*AW +: AW];
  end

  rdxbar_rr_pick #(
    .N (N)
  ) u_pick (
    .req (iDcpIn_Vld),
    .ptr (ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  // Zero-latency pass-through of the granted stream; handshakes are blocked while idle.
  always_comb begin
    oDcpOut_Pld = pld_arr[grant_q];
    oDcpOut_Dst = dst_arr[grant_q];
    oDcpOut_Vld = 1'b0;
    iDcpIn_Rdy  = '0;
    if (state_q == LOCK) begin
      oDcpOut_Vld         = iDcpIn_Vld[grant_q];
      iDcpIn_Rdy[grant_q] = oDcpOut_Rdy;
    end
  end

  assign beat_fire = oDcpOut_Vld & oDcpOut_Rdy;

  if (DW == PLD_W) begin : g_last_pkg
    assign beat_last = is_last(oDcpOut_Pld);
  end else begin : g_last_bit
    assign beat_last = oDcpOut_Pld[DW-1];
  end

  assign oBusy     = (state_q == LOCK);
  assign oGrantIdx = grant_q;

  // Arbitration FSM: grant in IDLE, release and advance the pointer on the accepted last beat.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            grant_q <= pick_idx;
            state_q <= LOCK;
          end
        end
        LOCK: begin
          if (beat_fire && beat_last) begin
            state_q <= IDLE;
            ptr_q   <= (grant_q == LastIdx) ? '0 : grant_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef RDXBAR_ARB_PKTCNT_EN
  logic [PKTCNT_W-1:0] cnt_q [N];

  // Count completed packets per requester, sticking at all-ones.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      for (int k = 0; k < N; k++) begin
        cnt_q[k] <= '0;
      end
    end else if (state_q == LOCK && beat_fire && beat_last && cnt_q[grant_q] != '1) begin
      cnt_q[grant_q] <= cnt_q[grant_q] + 1'b1;
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_cnt_out
    assign oPktCnt[k*PKTCNT_W +: PKTCNT_W] = cnt_q[k];
  end
`endif

endmodule
